// File: rtl/axi_read_burst_ctrl.sv
// AXI4 read-only slave front-end for a single-port SRAM behind an arbiter.
// Supports FIXED/INCR/WRAP and narrow bursts, with a read-data FIFO so memory reads run ahead of RREADY.
module axi_read_burst_ctrl #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_RDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int MEM_ADDR_WIDTH     = 13,
    parameter int RBUF_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
    input  logic [7:0]                    ARLEN_i,
    input  logic [2:0]                    ARSIZE_i,
    input  logic [1:0]                    ARBURST_i,
    input  logic                          ARLOCK_i,
    input  logic [3:0]                    ARCACHE_i,
    input  logic [2:0]                    ARPROT_i,
    input  logic [3:0]                    ARREGION_i,
    input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
    input  logic [3:0]                    ARQOS_i,
    input  logic                          ARVALID_i,
    output logic                          ARREADY_o,
    output logic [AXI4_ID_WIDTH-1:0]      RID_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
    output logic [1:0]                    RRESP_o,
    output logic                          RLAST_o,
    output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
    output logic                          RVALID_o,
    input  logic                          RREADY_i,
    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o,
    output logic [AXI4_RDATA_WIDTH/8-1:0] MEM_BE_o,
    input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,
    output logic                          valid_o,
    input  logic                          grant_i
);

    localparam int OFFSET = $clog2(AXI4_RDATA_WIDTH / 8);
    localparam int PTR_W  = $clog2(RBUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int AW     = AXI4_ADDRESS_WIDTH;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t state, state_next;

    logic [AXI4_ID_WIDTH-1:0]    id_q;
    logic [AXI4_USER_WIDTH-1:0]  user_q;
    logic [7:0]                  len_q;
    logic [2:0]                  size_q;
    logic [1:0]                  burst_q;
    logic [AW-1:0]               addr_q;
    logic [8:0]                  beats_issued;
    logic [8:0]                  beats_returned;
    logic                        inflight;

    logic [AXI4_RDATA_WIDTH-1:0] fifo_mem [RBUF_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            count;

    logic                        ar_hs;
    logic                        ar_legal;
    logic                        wrap_len_ok;
    logic [AW-1:0]               size_mask;
    logic [AW-1:0]               step;
    logic [AW-1:0]               wrap_mask;
    logic [AW-1:0]               addr_inc;
    logic [AW-1:0]               addr_next;
    logic [CNT_W-1:0]            occupancy;
    logic                        issue_req;
    logic                        mem_fire;
    logic                        fifo_empty;
    logic                        r_valid;
    logic                        r_last;
    logic                        r_hs;
    logic                        push;
    logic                        pop;

    logic unused_ar_sideband;
    assign unused_ar_sideband = ^{ARLOCK_i, ARCACHE_i, ARPROT_i, ARREGION_i, ARQOS_i};

    assign MEM_WEN_o = 1'b1;
    assign MEM_D_o   = '0;
    assign MEM_BE_o  = '0;
    assign MEM_A_o   = addr_q[MEM_ADDR_WIDTH+OFFSET-1:OFFSET];

    // Request legality is decided on the AR payload so ERR bursts never touch memory.
    always_comb begin
        ar_hs       = (state == IDLE) && ARVALID_i;
        wrap_len_ok = (ARLEN_i == 8'd1) || (ARLEN_i == 8'd3) || (ARLEN_i == 8'd7) || (ARLEN_i == 8'd15);
        size_mask   = (AW'(1) << ARSIZE_i) - AW'(1);
        ar_legal    = (ARBURST_i != BURST_RSVD) && (int'(ARSIZE_i) <= OFFSET) &&
                      ((ARBURST_i != BURST_WRAP) || (wrap_len_ok && ((ARADDR_i & size_mask) == '0)));
    end

    // Issue is throttled by FIFO space including the read still in flight, so pushes never overflow.
    always_comb begin
        step      = AW'(1) << size_q;
        wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
        addr_inc  = addr_q + step;
        addr_next = addr_inc;
        case (burst_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_next = addr_inc;
        endcase
        occupancy  = count + CNT_W'(inflight);
        issue_req  = (state == RUN) && (beats_issued <= {1'b0, len_q}) &&
                     (occupancy < CNT_W'(RBUF_DEPTH));
        mem_fire   = issue_req && grant_i;
        fifo_empty = (count == '0);
        r_valid    = ((state == RUN) && !fifo_empty) || (state == ERR);
        r_last     = (beats_returned == {1'b0, len_q});
        r_hs       = r_valid && RREADY_i;
        push       = inflight;
        pop        = r_hs && (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (ar_hs) state_next = ar_legal ? RUN : ERR;
            RUN, ERR: if (r_hs && r_last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Everything is forced quiet while rst_n is low, so a mid-burst reset is silent immediately.
    always_comb begin
        ARREADY_o = 1'b0;
        valid_o   = 1'b0;
        MEM_CEN_o = 1'b1;
        RVALID_o  = 1'b0;
        RLAST_o   = 1'b0;
        RRESP_o   = RESP_OKAY;
        RDATA_o   = '0;
        RID_o     = '0;
        RUSER_o   = '0;
        if (rst_n) begin
            ARREADY_o = (state == IDLE);
            valid_o   = issue_req;
            MEM_CEN_o = !issue_req;
            RVALID_o  = r_valid;
            RLAST_o   = r_valid && r_last;
            RRESP_o   = (state == ERR) ? RESP_SLVERR : RESP_OKAY;
            RDATA_o   = ((state == RUN) && !fifo_empty) ? fifo_mem[rd_ptr] : '0;
            RID_o     = id_q;
            RUSER_o   = user_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q           <= '0;
            user_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            addr_q         <= '0;
            beats_issued   <= '0;
            beats_returned <= '0;
            inflight       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            if (ar_hs) begin
                id_q           <= ARID_i;
                user_q         <= ARUSER_i;
                len_q          <= ARLEN_i;
                size_q         <= ARSIZE_i;
                burst_q        <= ARBURST_i;
                addr_q         <= ARADDR_i;
                beats_issued   <= '0;
                beats_returned <= '0;
            end
            if (mem_fire) begin
                addr_q       <= addr_next;
                beats_issued <= beats_issued + 9'd1;
            end
            inflight <= mem_fire;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (r_hs) beats_returned <= beats_returned + 9'd1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= MEM_Q_i;
    end

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Scoreboard bench for axi_read_burst_ctrl: expected beats and memory addresses come from
// a burst-level address model; monitors compare whenever the DUT presents a beat or an access.
module tb_axi_read_burst_ctrl;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [15:0] id;
        logic [9:0]  user;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] ARID_i;
    logic [31:0] ARADDR_i;
    logic [7:0]  ARLEN_i;
    logic [2:0]  ARSIZE_i;
    logic [1:0]  ARBURST_i;
    logic        ARLOCK_i;
    logic [3:0]  ARCACHE_i;
    logic [2:0]  ARPROT_i;
    logic [3:0]  ARREGION_i;
    logic [9:0]  ARUSER_i;
    logic [3:0]  ARQOS_i;
    logic        ARVALID_i;
    logic        ARREADY_o;
    logic [15:0] RID_o;
    logic [63:0] RDATA_o;
    logic [1:0]  RRESP_o;
    logic        RLAST_o;
    logic [9:0]  RUSER_o;
    logic        RVALID_o;
    logic        RREADY_i;
    logic        MEM_CEN_o;
    logic        MEM_WEN_o;
    logic [12:0] MEM_A_o;
    logic [63:0] MEM_D_o;
    logic [7:0]  MEM_BE_o;
    logic [63:0] MEM_Q_i;
    logic        valid_o;
    logic        grant_i;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ar_cyc = 0;
    int    acc_total = 0;
    int    gmode = 0;
    int    rmode = 0;
    beat_t exp_r[$];
    logic [12:0] exp_a[$];
    int    r_cycles[$];
    int    acc_cycles[$];

    axi_read_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
        .ARBURST_i(ARBURST_i), .ARLOCK_i(ARLOCK_i), .ARCACHE_i(ARCACHE_i), .ARPROT_i(ARPROT_i),
        .ARREGION_i(ARREGION_i), .ARUSER_i(ARUSER_i), .ARQOS_i(ARQOS_i),
        .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
        .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
        .RUSER_o(RUSER_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
        .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o), .MEM_D_o(MEM_D_o),
        .MEM_BE_o(MEM_BE_o), .MEM_Q_i(MEM_Q_i), .valid_o(valid_o), .grant_i(grant_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] word_data(input logic [12:0] a);
        return {16'hC0DE, 3'b000, a, 16'hBEEF ^ {3'b000, a}, 3'b000, ~a};
    endfunction

    // SRAM model: valid data only the cycle after a granted access, garbage otherwise.
    always @(posedge clk) begin
        if (!MEM_CEN_o && grant_i) MEM_Q_i <= word_data(MEM_A_o);
        else MEM_Q_i <= {$urandom, $urandom};
    end

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input logic [1:0] burst, input int i);
        logic [31:0] stp, w, base;
        stp = 32'(1) << size;
        if (burst == FIXED) return a;
        if (burst == WRAP) begin
            w    = stp * 32'(len + 1);
            base = a - (a % w);
            return base + ((a - base + stp * 32'(i)) % w);
        end
        return a + stp * 32'(i);
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input int len, input int size,
                                    input logic [1:0] burst);
        bit len_ok;
        len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        return (burst != 2'b11) && (size <= 3) &&
               ((burst != WRAP) || (len_ok && ((a % (32'(1) << size)) == 0)));
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    task automatic applyStimulus(input logic [15:0] id, input logic [31:0] addr, input int len,
                                 input int size, input logic [1:0] burst, input logic [9:0] user);
        bit got;
        bit legal;
        logic [12:0] w;
        beat_t b;
        got   = 0;
        legal = is_legal(addr, len, size, burst);
        @(posedge clk); #1;
        ARID_i = id; ARADDR_i = addr; ARLEN_i = 8'(len); ARSIZE_i = 3'(size);
        ARBURST_i = burst; ARUSER_i = user; ARVALID_i = 1'b1;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (ARREADY_o) begin
                got    = 1;
                ar_cyc = cyc;
                for (int i = 0; i <= len; i++) begin
                    if (legal) begin
                        w = beat_addr(addr, len, size, burst, i)[15:3];
                        exp_a.push_back(w);
                        b = '{word_data(w), 2'b00, (i == len), id, user};
                    end else begin
                        b = '{64'h0, 2'b10, (i == len), id, user};
                    end
                    exp_r.push_back(b);
                end
            end
        end
        if (!got) failNow("ar_timeout");
        @(posedge clk); #1;
        ARVALID_i = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles);
        bit done;
        done = 0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            @(negedge clk);
            done = (exp_r.size() == 0) && (exp_a.size() == 0);
        end
        checkOutput("burst_complete", 128'(done), 128'(1));
    endtask

    initial begin
        grant_i  = 1'b1;
        RREADY_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (gmode)
                1:       grant_i = ~grant_i;
                2:       grant_i = ($urandom_range(0, 3) != 0);
                default: grant_i = 1'b1;
            endcase
            case (rmode)
                1:       RREADY_i = 1'b0;
                2:       RREADY_i = ($urandom_range(0, 2) != 0);
                default: RREADY_i = 1'b1;
            endcase
        end
    end

    // R-channel monitor: pops the scoreboard on every handshake and checks stall stability.
    logic        r_stall = 1'b0;
    logic [93:0] r_prev;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            exp_r.delete();
            r_stall = 1'b0;
        end else begin
            if (r_stall)
                checkOutput("r_hold", 128'({RVALID_o, RDATA_o, RRESP_o, RLAST_o, RID_o, RUSER_o}), 128'(r_prev));
            if (RVALID_o && RREADY_i) begin
                r_cycles.push_back(cyc);
                if (exp_r.size() == 0) begin
                    failNow("unexpected_beat");
                end else begin
                    e = exp_r.pop_front();
                    checkOutput("rdata", 128'(RDATA_o), 128'(e.data));
                    checkOutput("rctl", 128'({RRESP_o, RLAST_o, RID_o, RUSER_o}),
                                128'({e.resp, e.last, e.id, e.user}));
                end
            end
            r_stall = RVALID_o && !RREADY_i;
            r_prev  = {RVALID_o, RDATA_o, RRESP_o, RLAST_o, RID_o, RUSER_o};
        end
    end

    // Memory monitor: every granted access must match the next modelled word address.
    logic        req_denied = 1'b0;
    logic [12:0] prev_a;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a.delete();
            req_denied = 1'b0;
        end else begin
            if (req_denied)
                checkOutput("req_hold", 128'({valid_o, MEM_A_o}), 128'({1'b1, prev_a}));
            checkOutput("mem_cen", 128'(MEM_CEN_o), 128'(!valid_o));
            if (valid_o && exp_a.size() == 0) begin
                failNow("unexpected_req");
            end else if (valid_o && grant_i) begin
                acc_cycles.push_back(cyc);
                acc_total++;
                checkOutput("mem_addr", 128'(MEM_A_o), 128'(exp_a.pop_front()));
            end
            req_denied = valid_o && !grant_i;
            prev_a     = MEM_A_o;
        end
    end

    initial begin
        int n_r, n_a, a0, len, size;
        logic [1:0]  burst;
        logic [31:0] addr;
        rst_n = 1'b0;
        ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0; ARSIZE_i = '0; ARBURST_i = '0;
        ARLOCK_i = 1'b0; ARCACHE_i = '0; ARPROT_i = '0; ARREGION_i = '0; ARUSER_i = '0;
        ARQOS_i = '0; ARVALID_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    128'({ARREADY_o, RVALID_o, RLAST_o, RRESP_o, RID_o, RUSER_o, RDATA_o, MEM_CEN_o, valid_o, MEM_WEN_o}),
                    128'({1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 10'h0, 64'h0, 1'b1, 1'b0, 1'b1}));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", 128'({ARREADY_o, RVALID_o, valid_o}), 128'(3'b100));

        $display("[TB] INCR latency and throughput");
        n_r = r_cycles.size();
        n_a = acc_cycles.size();
        applyStimulus(16'h0011, 32'h40, 3, 3, INCR, 10'h015);
        waitIdle(100);
        checkOutput("t1_first_access", 128'(acc_cycles[n_a] - ar_cyc), 128'(1));
        checkOutput("t1_access_span", 128'(acc_cycles[n_a+3] - acc_cycles[n_a]), 128'(3));
        checkOutput("t1_first_rvalid", 128'(r_cycles[n_r] - ar_cyc), 128'(3));
        checkOutput("t1_rvalid_span", 128'(r_cycles[n_r+3] - r_cycles[n_r]), 128'(3));

        $display("[TB] WRAP, FIXED and narrow INCR");
        applyStimulus(16'h0022, 32'h18, 3, 3, WRAP, 10'h022);
        waitIdle(100);
        applyStimulus(16'h0033, 32'h20, 2, 3, FIXED, 10'h033);
        waitIdle(100);
        applyStimulus(16'h0044, 32'h0, 3, 2, INCR, 10'h044);
        waitIdle(100);

        $display("[TB] RREADY stall fills the read buffer");
        rmode = 1;
        a0 = acc_total;
        applyStimulus(16'h0055, 32'h100, 7, 3, INCR, 10'h055);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_stall_accesses", 128'(acc_total - a0), 128'(4));
        rmode = 0;
        waitIdle(100);

        $display("[TB] Toggling grant");
        gmode = 1;
        applyStimulus(16'h0066, 32'h1F8, 15, 3, INCR, 10'h066);
        waitIdle(200);
        gmode = 0;

        $display("[TB] Illegal requests");
        applyStimulus(16'h0077, 32'h80, 1, 3, 2'b11, 10'h077);
        waitIdle(50);
        applyStimulus(16'h0078, 32'h80, 2, 4, INCR, 10'h078);
        waitIdle(50);
        applyStimulus(16'h0079, 32'h80, 2, 3, WRAP, 10'h079);
        waitIdle(50);
        applyStimulus(16'h007A, 32'h84, 3, 3, WRAP, 10'h07A);
        waitIdle(50);

        $display("[TB] 256-beat burst");
        gmode = 2; rmode = 2;
        applyStimulus(16'h0088, 32'h1FF00, 255, 3, INCR, 10'h088);
        waitIdle(3000);
        gmode = 0; rmode = 0;

        $display("[TB] Reset mid-burst");
        rmode = 1;
        applyStimulus(16'h0099, 32'h200, 7, 3, INCR, 10'h099);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid", 128'({RVALID_o, ARREADY_o, valid_o, MEM_CEN_o}), 128'(4'b0001));
        @(posedge clk); #1 rst_n = 1'b1;
        rmode = 0;
        @(negedge clk);
        checkOutput("rst_idle", 128'({ARREADY_o, RVALID_o, valid_o}), 128'(3'b100));
        applyStimulus(16'h00AA, 32'h48, 1, 3, INCR, 10'h0AA);
        waitIdle(100);

        $display("[TB] Random bursts");
        gmode = 2; rmode = 2;
        for (int t = 0; t < 30; t++) begin
            burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            size  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            addr  = $urandom;
            if (burst == WRAP) begin
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : ((2 << $urandom_range(0, 3)) - 1);
                if ($urandom_range(0, 4) != 0) addr = addr & ~((32'(1) << size) - 32'(1));
            end else begin
                len = int'($urandom_range(0, 20));
            end
            applyStimulus(16'($urandom), addr, len, size, burst, 10'($urandom));
            waitIdle(1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
